// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative multu/div/divu unit with HI/LO registers
// One shift-add or restoring-divide step per CALC cycle; result lands on the CALC->DONE edge.
module mdu_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam logic [4:0] LAST     = 5'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q, d_q;
  logic [63:0] work, work_next;
  logic [32:0] mul_sum, trial, diff;
  logic [63:0] mul_next, div_next;
  logic [31:0] res_hi, res_lo, quo, rem;
  logic        start_ok;

  assign start_ok = start && (op != OP_RSVD);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_ok) state_next = S_CALC;
      S_CALC:  if (cnt == LAST) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // work holds {partial product, multiplier} for multu and {remainder, dividend} for div/divu
  always_comb begin
    mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, a_q} : 33'd0);
    mul_next = {mul_sum, work[31:1]};
    trial    = {work[63:32], work[31]};
    diff     = trial - {1'b0, d_q};
    if (!diff[32])
      div_next = {diff[31:0], work[30:0], 1'b1};
    else
      div_next = {trial[31:0], work[30:0], 1'b0};
    work_next = (op_q == OP_MULTU) ? mul_next : div_next;
  end

  always_comb begin
    quo    = work_next[31:0];
    rem    = work_next[63:32];
    res_hi = rem;
    res_lo = quo;
    case (op_q)
      OP_MULTU: {res_hi, res_lo} = work_next;
      OP_DIV: begin
        // divide-by-zero must report the raw dividend, not a sign-corrected one
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_lo = (a_q[31] ^ b_q[31]) ? -quo : quo;
          res_hi = a_q[31] ? -rem : rem;
        end
      end
      default: begin
        res_hi = rem;
        res_lo = quo;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      op_q  <= 2'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      d_q   <= 32'd0;
      work  <= 64'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_CALC);
      done  <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            cnt  <= 5'd0;
            d_q  <= (op == OP_DIV && b[31]) ? -b : b;
            if (op == OP_MULTU)
              work <= {32'd0, b};
            else
              work <= {32'd0, (op == OP_DIV && a[31]) ? -a : a};
          end
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
        end
        S_CALC: begin
          work <= work_next;
          cnt  <= cnt + 5'd1;
          if (cnt == LAST) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed vector bench for mdu_ctrl
// Table of operations plus hand sequences for handshake, moves and reset abort.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mdu_ctrl #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] eh, input logic [31:0] el, input bit inject);
    int busy_n, done_at;
    op = o; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0; a = ~va; b = ~vb;
    busy_n = 0; done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_at = i;
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
      end
      if (inject && i == 5) begin
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        mthi = 1'b1; wdata = 32'hA5A5_A5A5;
      end
      tick();
      start = 1'b0; mthi = 1'b0;
    end
    chk({name, " busy cycles"}, 32'(busy_n), 32'd32);
    chk({name, " done cycle"}, 32'(done_at), 32'd33);
    chk({name, " idle after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int busy_n, done_n;
    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'b00, 32'd3,         32'd5,         32'h0,         32'hF};
    vecs[2]  = '{2'b00, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780};
    vecs[3]  = '{2'b00, 32'h8000_0000, 32'h2,         32'h1,         32'h0};
    vecs[4]  = '{2'b01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[6]  = '{2'b01, 32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
    vecs[7]  = '{2'b01, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h3};
    vecs[8]  = '{2'b01, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};
    vecs[9]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[10] = '{2'b10, 32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF};
    vecs[11] = '{2'b10, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF};

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    tick();
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
    chk("reset busy/done", {30'd0, busy, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    rst = 1'b0;
    tick();
    chk("post reset idle", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, 1'b0);

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_5A5A;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("move both hi", hi, 32'h5A5A_5A5A);
    chk("move both lo", lo, 32'h5A5A_5A5A);

    mthi = 1'b1; wdata = 32'h1111_1111;
    tick();
    mthi = 1'b0;
    chk("mthi only hi", hi, 32'h1111_1111);
    chk("mthi only lo", lo, 32'h5A5A_5A5A);

    op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rsvd op busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rsvd op busy/done later", {30'd0, busy, done}, 32'd0);
    chk("rsvd op hi", hi, 32'h1111_1111);
    chk("rsvd op lo", lo, 32'h5A5A_5A5A);

    run_op("restart ignored", 2'b00, 32'd3, 32'd5, 32'h0, 32'hF, 1'b1);

    op = 2'b10; a = 32'd100; b = 32'd7; mtlo = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0; mtlo = 1'b0;
    chk("mtlo with start lo", lo, 32'hDEAD_BEEF);
    chk("mtlo with start busy", {31'd0, busy}, 32'd1);
    done_n = 0;
    for (int i = 1; i <= 40 && done_n == 0; i++) begin
      if (done) begin
        done_n = 1;
        chk("mtlo overwrite hi", hi, 32'd2);
        chk("mtlo overwrite lo", lo, 32'd14);
      end
      tick();
    end
    chk("mtlo overwrite done seen", 32'(done_n), 32'd1);

    op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy/done", {30'd0, busy, done}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      tick();
    end
    chk("abort no busy", 32'(busy_n), 32'd0);
    chk("abort no done", 32'(done_n), 32'd0);
    chk("abort hi held", hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
